// File: rtl/mips_cpu_pkg.sv
// Shared opcode map, load/store FSM states and store-lane helpers
// for the MIPS CPU slice.
package mips_cpu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  function automatic logic is_load_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return is_load_op(op);
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] k);
    case (op)
      OP_LW, OP_SW:         return (k != 2'd0);
      OP_LH, OP_LHU, OP_SH: return k[0];
      default:              return 1'b0;
    endcase
  endfunction

  // Loads always fetch the whole word; lane extraction happens on return.
  function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] k);
    case (op)
      OP_SB:   return 4'b0001 << k;
      OP_SH:   return 4'b0011 << k;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wd(input logic [5:0] op, input logic [31:0] rt);
    case (op)
      OP_SB:   return {4{rt[7:0]}};
      OP_SH:   return {2{rt[15:0]}};
      default: return rt;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Load return path: lane select, sign/zero extension and LWL/LWR merge
// of the bus word with the old rt value.
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  logic [31:0] readdata,
  input  logic [1:0]  k,
  input  logic [5:0]  opcode,
  input  logic [31:0] rt,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] lwl_mask;
  logic [31:0] lwr_mask;

  always_comb begin
    sel_byte = readdata[{k, 3'b000} +: 8];
    sel_half = readdata[{k[1], 4'b0000} +: 16];

    // LWL keeps the low (3-k) bytes of rt, LWR keeps the high k bytes.
    case (k)
      2'd0:    begin lwl_mask = 32'h00FF_FFFF; lwr_mask = 32'h0000_0000; end
      2'd1:    begin lwl_mask = 32'h0000_FFFF; lwr_mask = 32'hFF00_0000; end
      2'd2:    begin lwl_mask = 32'h0000_00FF; lwr_mask = 32'hFFFF_0000; end
      default: begin lwl_mask = 32'h0000_0000; lwr_mask = 32'hFFFF_FF00; end
    endcase

    load_data = readdata;
    case (opcode)
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'h00_0000, sel_byte};
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'h0000, sel_half};
      OP_LWL:  load_data = (readdata << {~k, 3'b000}) | (rt & lwl_mask);
      OP_LWR:  load_data = (readdata >> {k, 3'b000}) | (rt & lwr_mask);
      default: load_data = readdata;
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_access.sv
// Load/store stage: runs one Avalon-MM data transaction per start pulse
// and returns the extended/merged load result for writeback.
module mips_cpu_mem_access
  import mips_cpu_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] eff_addr,
  input  logic [31:0] rt_content,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  state_t      state, state_nxt;
  logic [5:0]  op_q;
  logic [1:0]  k_q;
  logic [31:0] rt_q;
  logic [31:0] wait_cnt;
  logic [31:0] aligned;
  logic        timeout_hit;
  logic        req_ok;

  mips_cpu_load_align u_align (
    .readdata  (readdata),
    .k         (k_q),
    .opcode    (op_q),
    .rt        (rt_q),
    .load_data (aligned)
  );

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign req_ok      = is_mem_op(opcode) && !is_misaligned(opcode, eff_addr[1:0]);
  assign timeout_hit = (WAIT_TIMEOUT != 0) && waitrequest &&
                       (wait_cnt == WAIT_TIMEOUT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = req_ok ? ACCESS : DONE;
      ACCESS:  if (!waitrequest || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      k_q        <= '0;
      rt_q       <= '0;
      wait_cnt   <= '0;
      fault      <= 1'b0;
      load_data  <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      byteenable <= '0;
      writedata  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q     <= opcode;
          k_q      <= eff_addr[1:0];
          rt_q     <= rt_content;
          wait_cnt <= '0;
          fault    <= is_misaligned(opcode, eff_addr[1:0]);
          if (!is_mem_op(opcode)) begin
            load_data <= '0;
          end else if (req_ok) begin
            address    <= {eff_addr[31:2], 2'b00};
            read       <= is_load_op(opcode);
            write      <= !is_load_op(opcode);
            byteenable <= store_be(opcode, eff_addr[1:0]);
            writedata  <= store_wd(opcode, rt_content);
          end
        end
        ACCESS: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (is_load_op(op_q)) load_data <= aligned;
          end else if (timeout_hit) begin
            read  <= 1'b0;
            write <= 1'b0;
            fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_access.sv
// Directed bench for mips_cpu_mem_access: stimulus pushes the expected
// completion into a queue; a monitor pops and compares on every done.
module tb_mips_cpu_mem_access;
  import mips_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] eff_addr;
  logic [31:0] rt_content;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic [31:0] address;
  logic        read, write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  mips_cpu_mem_access #(.WAIT_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .eff_addr    (eff_addr),
    .rt_content  (rt_content),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .load_data   (load_data),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  typedef struct {
    string       name;
    logic        fault;
    logic [31:0] ld;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending request");
        end else begin
          e = sb_q.pop_front();
          check32({e.name, "_fault"}, 32'(fault), 32'(e.fault));
          check32({e.name, "_load_data"}, load_data, e.ld);
          check32({e.name, "_busy_in_done"}, 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic run_op(
    input string       name,
    input logic [5:0]  op,
    input logic [31:0] addr,
    input logic [31:0] rt,
    input logic [31:0] rdata,
    input int          nwait,
    input logic        exp_fault,
    input logic [31:0] exp_ld,
    input logic [31:0] exp_addr,
    input logic        exp_rd,
    input logic        exp_wr,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wd,
    input int          exp_lat,
    input int          exp_bus
  );
    exp_t e;
    int   lat, bus, j;
    logic seen;
    @(negedge clk);
    start       = 1'b1;
    opcode      = op;
    eff_addr    = addr;
    rt_content  = rt;
    readdata    = rdata;
    waitrequest = (nwait > 0);
    e.name = name; e.fault = exp_fault; e.ld = exp_ld;
    sb_q.push_back(e);
    lat = 0; bus = 0; j = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        // Request inputs are scrambled here; the unit must use its latched copy.
        start      = 1'b1;
        opcode     = OP_LW;
        eff_addr   = 32'hFFFF_FFF2;
        rt_content = 32'h5A5A_5A5A;
        if (read || write) begin
          bus++;
          check32({name, "_read"}, 32'(read), 32'(exp_rd));
          check32({name, "_write"}, 32'(write), 32'(exp_wr));
          check32({name, "_address"}, address, exp_addr);
          check32({name, "_byteenable"}, 32'(byteenable), 32'(exp_be));
          if (exp_wr) check32({name, "_writedata"}, writedata, exp_wd);
          waitrequest = (j < nwait);
          j++;
        end
      end
    end
    start       = 1'b0;
    waitrequest = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_no_done: got no done within 40 cycles expected done", name);
    end
    check32({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check32({name, "_bus_cycles"}, 32'(bus), 32'(exp_bus));
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    opcode      = '0;
    eff_addr    = '0;
    rt_content  = '0;
    waitrequest = 1'b0;
    readdata    = '0;
    @(negedge clk);
    @(negedge clk);
    check32("reset_ctrl", {27'd0, busy, done, fault, read, write}, 32'd0);
    check32("reset_address", address, 32'd0);
    check32("reset_byteenable", 32'(byteenable), 32'd0);
    check32("reset_writedata", writedata, 32'd0);
    check32("reset_load_data", load_data, 32'd0);
    reset = 1'b0;

    //     name        op      addr          rt            rdata         nw  flt ld            addr          rd wr be       wd            lat bus
    run_op("lw",       OP_LW,  32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 32'h0000_1004, 1, 0, 4'b1111, 32'h0,        2, 1);
    run_op("lb",       OP_LB,  32'h0000_1003, 32'h0,        32'h80FF_7F01, 0, 0, 32'hFFFF_FF80, 32'h0000_1000, 1, 0, 4'b1111, 32'h0,        2, 1);
    run_op("lbu",      OP_LBU, 32'h0000_1003, 32'h0,        32'h80FF_7F01, 0, 0, 32'h0000_0080, 32'h0000_1000, 1, 0, 4'b1111, 32'h0,        2, 1);
    run_op("sh_wait",  OP_SH,  32'h0000_2002, 32'h1234_ABCD, 32'h0,        3, 0, 32'h0000_0080, 32'h0000_2000, 0, 1, 4'b1100, 32'hABCD_ABCD, 5, 4);
    run_op("lwl",      OP_LWL, 32'h0000_3001, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 32'h2211_CCDD, 32'h0000_3000, 1, 0, 4'b1111, 32'h0,        2, 1);
    run_op("lwr",      OP_LWR, 32'h0000_3002, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 32'hAABB_4433, 32'h0000_3000, 1, 0, 4'b1111, 32'h0,        2, 1);
    run_op("lh",       OP_LH,  32'h0000_1002, 32'h0,        32'h80FF_7F01, 1, 0, 32'hFFFF_80FF, 32'h0000_1000, 1, 0, 4'b1111, 32'h0,        3, 2);
    run_op("lhu",      OP_LHU, 32'h0000_1000, 32'h0,        32'h80FF_7F01, 0, 0, 32'h0000_7F01, 32'h0000_1000, 1, 0, 4'b1111, 32'h0,        2, 1);
    run_op("sb",       OP_SB,  32'h0000_4001, 32'h1234_56A5, 32'h0,        0, 0, 32'h0000_7F01, 32'h0000_4000, 0, 1, 4'b0010, 32'hA5A5_A5A5, 2, 1);
    run_op("sw",       OP_SW,  32'h0000_4000, 32'hCAFE_F00D, 32'h0,        0, 0, 32'h0000_7F01, 32'h0000_4000, 0, 1, 4'b1111, 32'hCAFE_F00D, 2, 1);
    run_op("lw_mis",   OP_LW,  32'h0000_1002, 32'h0,        32'hFFFF_FFFF, 0, 1, 32'h0000_7F01, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 0);
    run_op("sh_mis",   OP_SH,  32'h0000_2001, 32'h1111_2222, 32'h0,        0, 1, 32'h0000_7F01, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 0);
    run_op("addiu",    OP_ADDIU, 32'h0000_1234, 32'h0,      32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 0);
    run_op("lb_pos",   OP_LB,  32'h0000_5003, 32'h0,        32'h7F00_0000, 0, 0, 32'h0000_007F, 32'h0000_5000, 1, 0, 4'b1111, 32'h0,        2, 1);
    run_op("lw_tmo",   OP_LW,  32'h0000_5000, 32'h0,        32'h1111_1111, 100, 1, 32'h0000_007F, 32'h0000_5000, 1, 0, 4'b1111, 32'h0,    5, 4);

    // Reset in the middle of a stalled read: bus and busy drop at once, no done.
    @(negedge clk);
    start       = 1'b1;
    opcode      = OP_LW;
    eff_addr    = 32'h0000_1008;
    waitrequest = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check32("rst_pre_read", 32'(read), 32'd1);
    #2 reset = 1'b1;
    #1;
    check32("rst_read_drop", 32'(read), 32'd0);
    check32("rst_busy_drop", 32'(busy), 32'd0);
    check32("rst_load_data", load_data, 32'd0);
    @(negedge clk);
    reset       = 1'b0;
    waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check32("rst_idle_after", 32'(busy), 32'd0);

    run_op("lw_post",  OP_LW,  32'h0000_1004, 32'h0,        32'h1234_5678, 0, 0, 32'h1234_5678, 32'h0000_1004, 1, 0, 4'b1111, 32'h0,        2, 1);

    repeat (3) @(negedge clk);
    check32("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
